// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: core/loader arbiter in front of one synchronous single-port memory.
// Latency: gnt one cycle after the req sample edge; rvalid RD_LAT+1 cycles after gnt; writes done in the gnt cycle.
// Backpressure: no queueing; a requester holds req high and stays pending until it wins in IDLE or RESP.
//
// Config : `define RISCV_ARB_ROUND_ROBIN_EN -> round-robin tie-break; undefined -> core has fixed priority.
// Ports  : clk, rst (asynchronous, active-high)
//          c_* / l_* : req, we, addr, wdata in; gnt, rvalid (one-cycle pulses), rdata (held) out
//          m_*       : en, we, addr, wdata out; rdata in (valid RD_LAT cycles after the m_en cycle)
//          busy      : FSM is not in IDLE
// RD_LAT legal range is 1..7 (3-bit wait counter).
module riscv_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t     state, state_nxt;
   req_t       cur;        // request that won the last arbitration
   req_t       win;        // request that would win right now
   logic       owner;      // 0 = core, 1 = loader
   logic [2:0] wait_cnt;
   logic       arb_ok;     // FSM is at an arbitration point
   logic       take;       // a request is latched at this edge
   logic       pick_l;     // loader wins the current arbitration

`ifdef RISCV_ARB_ROUND_ROBIN_EN
   logic last_winner;      // 0 = core, 1 = loader

   // A tie goes to whoever did not win last time.
   assign pick_l = l_req & (~c_req | ~last_winner);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_winner <= 1'b1;   // loader, so the core takes the first tie
      end else if (take) begin
         last_winner <= pick_l;
      end
   end
`else
   assign pick_l = l_req & ~c_req;
`endif

   assign take = arb_ok & (c_req | l_req);
   assign win  = pick_l ? {l_we, l_addr, l_wdata} : {c_we, c_addr, c_wdata};

   // Memory address/data simply follow the latched request; m_en qualifies them.
   assign m_addr  = cur.addr;
   assign m_wdata = cur.wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      arb_ok    = 1'b0;
      m_en      = 1'b0;
      m_we      = 1'b0;
      c_gnt     = 1'b0;
      l_gnt     = 1'b0;
      c_rvalid  = 1'b0;
      l_rvalid  = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            arb_ok = 1'b1;
            if (c_req | l_req) state_nxt = ACCESS;
         end
         ACCESS: begin
            m_en      = 1'b1;
            m_we      = cur.we;
            c_gnt     = ~owner;
            l_gnt     = owner;
            state_nxt = cur.we ? IDLE : WAIT;
         end
         WAIT: begin
            if (wait_cnt == 3'd0) state_nxt = RESP;
         end
         RESP: begin
            c_rvalid  = ~owner;
            l_rvalid  = owner;
            arb_ok    = 1'b1;
            state_nxt = (c_req | l_req) ? ACCESS : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur      <= '0;
         owner    <= 1'b0;
         wait_cnt <= 3'd0;
         c_rdata  <= '0;
         l_rdata  <= '0;
      end else begin
         if (take) begin
            cur   <= win;
            owner <= pick_l;
         end
         // Count down RD_LAT WAIT cycles; the zero count marks the last one.
         if (state == ACCESS && !cur.we) begin
            wait_cnt <= 3'(RD_LAT - 1);
         end else if (state == WAIT && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
         end
         if (state == WAIT && wait_cnt == 3'd0) begin
            if (owner) l_rdata <= m_rdata;
            else       c_rdata <= m_rdata;
         end
      end
   end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, memory read latency in cycles; legal range 1..7.
REQ-004 The block SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have ports c_req / l_req  in  1  access request from core (c_) or loader (l_).
REQ-007 The block SHALL have ports c_we / l_we  in  1  request is a write (1) or a read (0).
REQ-008 The block SHALL have ports c_addr / l_addr  in  ADDR_W  request address.
REQ-009 The block SHALL have ports c_wdata / l_wdata  in  DATA_W  write data.
REQ-010 The block SHALL have ports c_gnt / l_gnt  out  1  one-cycle pulse: request accepted.
REQ-011 The block SHALL have ports c_rvalid / l_rvalid  out  1  one-cycle pulse: read data valid.
REQ-012 The block SHALL have ports c_rdata / l_rdata  out  DATA_W  registered read data.
REQ-013 The block SHALL have ports m_en, m_we  out  1  memory enable and write strobe.
REQ-014 The block SHALL have ports m_addr / m_wdata  out  ADDR_W / DATA_W  memory address and write data.
REQ-015 The block SHALL have port m_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after the m_en cycle.
REQ-016 The block SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, ACCESS, WAIT and RESP.
REQ-018 Arbitration SHALL occur only in IDLE and RESP; a request sampled high at the rising edge SHALL latch the winner's we, addr and wdata and move the FSM to ACCESS.
REQ-019 If no request is present, IDLE SHALL stay in IDLE and RESP SHALL go to IDLE.
REQ-020 In ACCESS (exactly one cycle) the block SHALL drive m_en=1, m_we=latched we, m_addr and m_wdata from the latched values, and pulse the winner's gnt.
REQ-021 ACCESS SHALL go to IDLE for a write and to WAIT for a read.
REQ-022 A 3-bit counter SHALL hold the FSM in WAIT for RD_LAT cycles; m_rdata SHALL be registered into the owner's rdata on the last WAIT cycle, and the FSM SHALL then go to RESP.
REQ-023 In RESP the owner's rvalid SHALL be 1 for one cycle; rdata SHALL hold its value until the owner's next read capture.
REQ-024 Read latency SHALL be req sample edge -> gnt in the next cycle -> rvalid RD_LAT+1 cycles after gnt; writes SHALL complete in the gnt cycle.
REQ-025 Requester rule: after gnt, req SHALL be low for a read until the rvalid cycle; for a write it may be reasserted in the cycle after gnt. The arbiter SHALL NOT mask a violation and SHALL issue a fresh access.
REQ-026 When both requests are present at one arbitration point, the winner SHALL be chosen per REQ-033/034; the loser SHALL stay pending without being dropped.
REQ-027 Outside ACCESS, m_en and m_we SHALL be 0; gnt and rvalid SHALL never be high for both ports in the same cycle.

Reset
REQ-028 On rst the FSM SHALL go to IDLE immediately; any in-flight access SHALL be aborted, and no gnt or rvalid SHALL follow.
REQ-029 During and after reset, all outputs SHALL be 0, including c_rdata/l_rdata and busy, and the WAIT counter SHALL be 0.
REQ-030 During and after reset, the round-robin pointer SHALL be last_winner=loader, so the core wins the first tie.

Configuration
REQ-031 The block SHALL use macro RISCV_ARB_ROUND_ROBIN_EN.
REQ-032 With or without the macro, a single requester SHALL always be served.
REQ-033 With the macro defined, a tie SHALL go to the port that is not last_winner, and last_winner SHALL update on every grant.
REQ-034 Without the macro, the core SHALL win every tie (fixed priority), and no pointer register SHALL exist.

Verification
REQ-035 With RD_LAT=1, a core read of addr 0x10 (mem=0xDEADBEEF) SHALL give c_gnt in cycle 1 and c_rvalid in cycle 3 with c_rdata=0xDEADBEEF; l_* outputs SHALL stay 0.
REQ-036 A loader write of addr 0x20, data 0x12345678 SHALL give m_en=m_we=1 for exactly one cycle with those values, and l_gnt in that cycle; busy SHALL be 0 the next cycle.
REQ-037 With both ports continuously issuing writes and the macro defined, grants SHALL go c,l,c,l; with the macro undefined, every grant SHALL go to the core.
REQ-038 With RD_LAT=4, a read SHALL give rvalid exactly 5 cycles after gnt; a loader request arriving during WAIT SHALL be granted in the cycle after RESP.
REQ-039 Asserting rst during WAIT SHALL make busy=0 and m_en=0 asynchronously, with no rvalid; after release, a core read SHALL complete normally.
